// File: rtl/proc_run_ctrl.sv
// Run-control front end: idle / free / divided / single-step clock-enable generation,
// result capture and cycle counting. Optional breakpoint: define PROC_RUN_CTRL_BREAKPOINT_EN.
module proc_run_ctrl #(
    parameter int OUT_W       = 16,
    parameter int DIV_W       = 8,
    parameter int CNT_W       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic [DIV_W-1:0] div_val,
    input  logic             step_btn,
    input  logic             halt_req,
    input  logic [OUT_W-1:0] dp_out,
`ifdef PROC_RUN_CTRL_BREAKPOINT_EN
    input  logic             bp_valid,
    input  logic [CNT_W-1:0] bp_cycle,
    output logic             bp_hit,
`endif
    output logic             dp_ce,
    output logic [OUT_W-1:0] out,
    output logic [CNT_W-1:0] cycle_count,
    output logic             running,
    output logic             halted
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN_FREE,
        S_RUN_DIV,
        S_STEP,
        S_HALTED
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    state_t                 w_mode_st;
    logic                   w_ce_nxt;
    logic                   w_edge;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_btn_q;
    logic [DIV_W-1:0]       r_div_cnt;
    logic [DIV_W-1:0]       r_div_lim;
    logic                   r_dp_ce;
    logic [OUT_W-1:0]       r_out;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_running;
    logic                   r_halted;
`ifdef PROC_RUN_CTRL_BREAKPOINT_EN
    logic                   w_bp;
    logic [CNT_W-1:0]       w_cnt_after;
    logic                   r_bp_hit;
`endif

    assign w_edge = r_sync[SYNC_STAGES-1] & ~r_btn_q;

    always_comb begin
        w_state_nxt = r_state;
        w_ce_nxt    = 1'b0;
        case (mode)
            2'b01:   w_mode_st = S_RUN_FREE;
            2'b10:   w_mode_st = S_RUN_DIV;
            2'b11:   w_mode_st = S_STEP;
            default: w_mode_st = S_IDLE;
        endcase
`ifdef PROC_RUN_CTRL_BREAKPOINT_EN
        w_bp        = 1'b0;
        // Count value once the pulse decided here has itself been counted.
        w_cnt_after = r_cnt + CNT_W'(r_dp_ce) + CNT_W'(1);
`endif
        case (r_state)
            S_IDLE:     w_state_nxt = w_mode_st;
            S_RUN_FREE, S_RUN_DIV, S_STEP: begin
                if (halt_req) begin
                    w_state_nxt = S_HALTED;
                end else if (w_mode_st != r_state) begin
                    w_state_nxt = w_mode_st;
                end else begin
                    case (r_state)
                        S_RUN_FREE: w_ce_nxt = 1'b1;
                        S_RUN_DIV:  w_ce_nxt = (r_div_cnt == r_div_lim);
                        S_STEP:     w_ce_nxt = w_edge;
                        default:    w_ce_nxt = 1'b0;
                    endcase
                end
            end
            S_HALTED: begin
                if (mode == 2'b00) w_state_nxt = S_IDLE;
            end
            default:    w_state_nxt = S_IDLE;
        endcase
`ifdef PROC_RUN_CTRL_BREAKPOINT_EN
        if (w_ce_nxt && bp_valid && (w_cnt_after == bp_cycle)) begin
            w_state_nxt = S_HALTED;
            w_bp        = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_sync    <= '0;
            r_btn_q   <= 1'b0;
            r_div_cnt <= '0;
            r_div_lim <= '0;
            r_dp_ce   <= 1'b0;
            r_out     <= '0;
            r_cnt     <= '0;
            r_running <= 1'b0;
            r_halted  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_sync    <= {r_sync[SYNC_STAGES-2:0], step_btn};
            r_btn_q   <= r_sync[SYNC_STAGES-1];
            // Divider restarts on any state change and samples div_val at each reload.
            if (r_state == S_RUN_DIV && w_state_nxt == S_RUN_DIV) begin
                if (r_div_cnt == r_div_lim) begin
                    r_div_cnt <= '0;
                    r_div_lim <= div_val;
                end else begin
                    r_div_cnt <= r_div_cnt + DIV_W'(1);
                end
            end else begin
                r_div_cnt <= '0;
                r_div_lim <= div_val;
            end
            r_dp_ce   <= w_ce_nxt;
            if (r_dp_ce) begin
                r_out <= dp_out;
                r_cnt <= r_cnt + CNT_W'(1);
            end
            r_running <= (w_state_nxt == S_RUN_FREE) || (w_state_nxt == S_RUN_DIV) ||
                         (w_state_nxt == S_STEP);
            r_halted  <= (w_state_nxt == S_HALTED);
        end
    end

`ifdef PROC_RUN_CTRL_BREAKPOINT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bp_hit <= 1'b0;
        end else begin
            r_bp_hit <= (w_state_nxt == S_HALTED) &&
                        (w_bp || (r_state == S_HALTED && r_bp_hit));
        end
    end

    assign bp_hit = r_bp_hit;
`endif

    assign dp_ce       = r_dp_ce;
    assign out         = r_out;
    assign cycle_count = r_cnt;
    assign running     = r_running;
    assign halted      = r_halted;

endmodule

// File: tb/tb_proc_run_ctrl.sv
// Self-checking bench for proc_run_ctrl: table of run-mode vectors, out/count scoreboard,
// hand sequences for reset, divider reload, step, halt and (when enabled) breakpoint.
module tb_proc_run_ctrl;

    localparam int OUT_W = 16;
    localparam int DIV_W = 8;
    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [1:0]       mode = 2'b00;
    logic [DIV_W-1:0] div_val = '0;
    logic             step_btn = 1'b0;
    logic             halt_req = 1'b0;
    logic [OUT_W-1:0] dp_out = '0;
    logic             dp_ce;
    logic [OUT_W-1:0] out;
    logic [CNT_W-1:0] cycle_count;
    logic             running;
    logic             halted;
`ifdef PROC_RUN_CTRL_BREAKPOINT_EN
    logic             bp_valid = 1'b0;
    logic [CNT_W-1:0] bp_cycle = '0;
    logic             bp_hit;
`endif

    proc_run_ctrl #(
        .OUT_W      (OUT_W),
        .DIV_W      (DIV_W),
        .CNT_W      (CNT_W),
        .SYNC_STAGES(2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mode       (mode),
        .div_val    (div_val),
        .step_btn   (step_btn),
        .halt_req   (halt_req),
        .dp_out     (dp_out),
`ifdef PROC_RUN_CTRL_BREAKPOINT_EN
        .bp_valid   (bp_valid),
        .bp_cycle   (bp_cycle),
        .bp_hit     (bp_hit),
`endif
        .dp_ce      (dp_ce),
        .out        (out),
        .cycle_count(cycle_count),
        .running    (running),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    int               n_tests = 0;
    int               n_fail  = 0;
    logic [OUT_W-1:0] sb_q[$];
    logic [OUT_W-1:0] exp_out = '0;
    logic [CNT_W-1:0] exp_cnt = '0;
    logic             prev_ce = 1'b0;

    typedef struct {
        logic [1:0]       mode;
        logic [DIV_W-1:0] div;
        int               n;
        int               exp_pulses;
        int               exp_first;
        int               exp_gap;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: sample after the edge, score out/cycle_count, then drive fresh dp_out.
    task automatic tick();
        @(posedge clk);
        #1;
        if (prev_ce) exp_cnt++;
        if (sb_q.size() > 0) exp_out = sb_q.pop_front();
        chk("out", out, exp_out);
        chk("cycle_count", cycle_count, exp_cnt);
        dp_out = OUT_W'($urandom);
        if (dp_ce) sb_q.push_back(dp_out);
        prev_ce = dp_ce;
    endtask

    task automatic reset_dut();
        #3;
        rst      = 1'b1;
        mode     = 2'b00;
        halt_req = 1'b0;
        step_btn = 1'b0;
`ifdef PROC_RUN_CTRL_BREAKPOINT_EN
        bp_valid = 1'b0;
`endif
        #1;
        chk("rst_dp_ce", dp_ce, 0);
        chk("rst_out", out, 0);
        chk("rst_cycle_count", cycle_count, 0);
        chk("rst_running", running, 0);
        chk("rst_halted", halted, 0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        sb_q.delete();
        exp_out = '0;
        exp_cnt = '0;
        prev_ce = 1'b0;
    endtask

    task automatic run_count(input int n, input int exp_first, input int exp_gap,
                             output int pulses);
        int last;
        pulses = 0;
        last   = 0;
        for (int k = 1; k <= n; k++) begin
            tick();
            if (dp_ce) begin
                pulses++;
                if (pulses == 1) begin
                    if (exp_first > 0) chk("first_pulse", k, exp_first);
                end else if (exp_gap > 0) begin
                    chk("pulse_gap", k - last, exp_gap);
                end
                last = k;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int p;
        tbl[0] = '{2'b01, 8'd0, 11, 10, 2, 1};
        tbl[1] = '{2'b10, 8'd3, 41, 10, 5, 4};
        tbl[2] = '{2'b10, 8'd0, 12, 11, 2, 1};
        tbl[3] = '{2'b10, 8'd1, 20,  9, 3, 2};
        tbl[4] = '{2'b00, 8'd0,  8,  0, 0, 0};
        tbl[5] = '{2'b10, 8'd7, 30,  3, 9, 8};

        reset_dut();

        for (int i = 0; i < 6; i++) begin
            reset_dut();
            mode    = tbl[i].mode;
            div_val = tbl[i].div;
            run_count(tbl[i].n, tbl[i].exp_first, tbl[i].exp_gap, p);
            chk("vec_pulses", p, tbl[i].exp_pulses);
            chk("vec_running", running, (tbl[i].mode != 2'b00));
            mode = 2'b00;
            tick();
            chk("vec_final_count", cycle_count, tbl[i].exp_pulses);
            chk("vec_idle_dp_ce", dp_ce, 0);
            chk("vec_idle_running", running, 0);
        end

        // Asynchronous reset in the middle of a free run.
        reset_dut();
        mode = 2'b01;
        repeat (6) tick();
        chk("prerst_count", cycle_count, 4);
        chk("prerst_dp_ce", dp_ce, 1);
        reset_dut();
        tick();
        chk("postrst_running", running, 0);
        chk("postrst_dp_ce", dp_ce, 0);

        // div_val change lands at the next reload.
        reset_dut();
        mode    = 2'b10;
        div_val = 8'd3;
        run_count(9, 5, 4, p);
        chk("div_pre_pulses", p, 2);
        div_val = 8'd0;
        for (int k = 10; k <= 16; k++) begin
            tick();
            chk("div_reload_ce", dp_ce, (k >= 13));
        end

        // Free run to divided run: divider restarts from zero.
        reset_dut();
        mode = 2'b01;
        repeat (4) tick();
        mode    = 2'b10;
        div_val = 8'd2;
        run_count(10, 4, 3, p);
        chk("modechg_pulses", p, 3);

        // Step button ignored in idle, then three presses in step mode.
        reset_dut();
        step_btn = 1'b1;
        run_count(6, 0, 0, p);
        chk("idle_btn_pulses", p, 0);
        step_btn = 1'b0;
        repeat (4) tick();
        mode = 2'b11;
        repeat (3) tick();
        for (int b = 0; b < 3; b++) begin
            #3;
            step_btn = 1'b1;
            run_count(20, 3, 0, p);
            chk("step_press_pulses", p, 1);
            step_btn = 1'b0;
            run_count(5, 0, 0, p);
            chk("step_gap_pulses", p, 0);
        end
        mode = 2'b00;
        tick();
        chk("step_count", cycle_count, 3);

        // Halt in free run, exit via idle, resume counting.
        reset_dut();
        mode = 2'b01;
        repeat (7) tick();
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        chk("halt_dp_ce", dp_ce, 0);
        chk("halt_halted", halted, 1);
        chk("halt_running", running, 0);
        chk("halt_count", cycle_count, 6);
        mode = 2'b10;
        run_count(5, 0, 0, p);
        chk("halted_pulses", p, 0);
        chk("halted_stay", halted, 1);
        chk("halted_count", cycle_count, 6);
        mode = 2'b00;
        tick();
        chk("unhalt_halted", halted, 0);
        chk("unhalt_running", running, 0);
        halt_req = 1'b1;
        repeat (2) tick();
        chk("idle_halt_ignored", halted, 0);
        halt_req = 1'b0;
        mode = 2'b01;
        run_count(5, 2, 1, p);
        chk("resume_pulses", p, 4);
        mode = 2'b00;
        tick();
        chk("resume_count", cycle_count, 10);

        // Halt beats a divider terminal count.
        reset_dut();
        mode    = 2'b10;
        div_val = 8'd3;
        repeat (4) tick();
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        chk("halt_tc_dp_ce", dp_ce, 0);
        chk("halt_tc_halted", halted, 1);
        tick();
        chk("halt_tc_count", cycle_count, 0);

`ifdef PROC_RUN_CTRL_BREAKPOINT_EN
        reset_dut();
        bp_valid = 1'b1;
        bp_cycle = 32'd5;
        mode     = 2'b01;
        run_count(15, 2, 1, p);
        chk("bp_pulses", p, 5);
        chk("bp_halted", halted, 1);
        chk("bp_hit", bp_hit, 1);
        chk("bp_running", running, 0);
        chk("bp_count", cycle_count, 5);
        mode = 2'b00;
        tick();
        chk("bp_hit_clear", bp_hit, 0);
        chk("bp_exit_halted", halted, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
